// File: rtl/calc_bank_pkg.sv
// rtl/calc_bank_pkg.sv - opcode, history entry and signed-limit helpers for calc_bank
package calc_bank_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_LOAD = 3'b111
  } op_t;

  // Entry fields are sized for the largest supported bank; unused upper bits are constant zero.
  localparam int HIST_IDX_W = 8;
  localparam int HIST_VAL_W = 64;

  typedef struct packed {
    logic [HIST_IDX_W-1:0] idx;
    logic [HIST_VAL_W-1:0] value;
  } hist_entry_t;

  function automatic logic [HIST_VAL_W-1:0] signed_max(input int w);
    return (HIST_VAL_W'(1) << (w - 1)) - HIST_VAL_W'(1);
  endfunction

  function automatic logic [HIST_VAL_W-1:0] signed_min(input int w);
    return HIST_VAL_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/calc_hist.sv
// rtl/calc_hist.sv - circular LIFO undo history; a push when full overwrites the oldest entry
module calc_hist
  import calc_bank_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  hist_entry_t              i_push_data,
  output hist_entry_t              o_top_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  hist_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   w_top_ptr;

  assign w_top_ptr  = r_wr_ptr - PTR_W'(1);
  assign o_top_data = r_mem[w_top_ptr];
  assign o_count    = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // The write slot one past the newest is also the oldest slot once full, so wrapping overwrites it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (r_count != FULL) begin
        r_count <= r_count + (PTR_W + 1)'(1);
      end
    end else if (i_pop && (r_count != '0)) begin
      r_wr_ptr <= w_top_ptr;
      r_count  <= r_count - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/calc_bank.sv
// rtl/calc_bank.sv - bank of signed accumulators driven by board buttons, with undo history
module calc_bank
  import calc_bank_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_ACC    = 4,
  parameter int HIST_DEPTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          btnu,
  input  logic                          btnc,
  input  logic                          btnl,
  input  logic                          btnr,
  input  logic                          btnd,
  input  logic                          btn_undo,
  input  logic [$clog2(NUM_ACC)-1:0]    acc_sel,
  input  logic [WIDTH-1:0]              sw,
  output logic [WIDTH-1:0]              led,
  output logic                          zero,
  output logic                          ovf,
  output logic [$clog2(HIST_DEPTH):0]   hist_cnt
);

  localparam int IDX_W = $clog2(NUM_ACC);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int MSB   = WIDTH - 1;
  localparam logic [HIST_VAL_W-1:0] MAX_FULL = signed_max(WIDTH);
  localparam logic [HIST_VAL_W-1:0] MIN_FULL = signed_min(WIDTH);
  localparam logic [WIDTH-1:0] MAX_V = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_V = MIN_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_acc [NUM_ACC];
  logic             r_btnd_q;
  logic             r_undo_q;
  logic             r_ovf;

  logic              w_commit;
  logic              w_undo;
  logic              w_restore;
  op_t               w_op;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  w_diff;
  logic              w_add_ovf;
  logic              w_sub_ovf;
  logic [WIDTH-1:0]  w_clamp;
  logic [SH_W-1:0]   w_shamt;
  logic [WIDTH-1:0]  w_res;
  logic              w_ovf;
  hist_entry_t       w_push_data;
  hist_entry_t       w_top;
  logic [IDX_W-1:0]  w_rest_idx;
  logic [WIDTH-1:0]  w_rest_val;

  assign w_commit  = btnd & ~r_btnd_q;
  // An undo colliding with a commit is dropped, not queued.
  assign w_undo    = btn_undo & ~r_undo_q & ~w_commit;
  assign w_restore = w_undo & (hist_cnt != '0);

  assign w_op      = op_t'({btnc, btnl, btnr});
  assign w_a       = r_acc[acc_sel];
  assign w_sum     = w_a + sw;
  assign w_diff    = w_a - sw;
  assign w_add_ovf = (w_a[MSB] == sw[MSB]) && (w_sum[MSB] != w_a[MSB]);
  assign w_sub_ovf = (w_a[MSB] != sw[MSB]) && (w_diff[MSB] != w_a[MSB]);
  // On overflow the true result lies beyond the limit on the side of A's sign.
  assign w_clamp   = w_a[MSB] ? MIN_V : MAX_V;
  assign w_shamt   = sw[SH_W-1:0];

  always_comb begin
    w_res = w_a;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_ovf = w_add_ovf;
        w_res = (w_add_ovf && (SATURATE != 0)) ? w_clamp : w_sum;
      end
      OP_SUB: begin
        w_ovf = w_sub_ovf;
        w_res = (w_sub_ovf && (SATURATE != 0)) ? w_clamp : w_diff;
      end
      OP_AND:  w_res = w_a & sw;
      OP_OR:   w_res = w_a | sw;
      OP_XOR:  w_res = w_a ^ sw;
      OP_SLL:  w_res = w_a << w_shamt;
      OP_SRA:  w_res = $signed(w_a) >>> w_shamt;
      OP_LOAD: w_res = sw;
      default: w_res = w_a;
    endcase
  end

  assign w_push_data = '{idx: HIST_IDX_W'(acc_sel), value: HIST_VAL_W'(w_a)};
  assign w_rest_idx  = IDX_W'(w_top.idx);
  assign w_rest_val  = WIDTH'(w_top.value);

  calc_hist #(
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .i_clk       (clk),
    .i_rst       (btnu),
    .i_push      (w_commit),
    .i_pop       (w_undo),
    .i_push_data (w_push_data),
    .o_top_data  (w_top),
    .o_count     (hist_cnt)
  );

  // Edge registers reset high so a button held through reset release does not fire.
  always_ff @(posedge clk) begin
    if (btnu) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        r_acc[i] <= '0;
      end
      r_ovf    <= 1'b0;
      r_btnd_q <= 1'b1;
      r_undo_q <= 1'b1;
    end else begin
      r_btnd_q <= btnd;
      r_undo_q <= btn_undo;
      if (w_commit) begin
        r_acc[acc_sel] <= w_res;
        r_ovf          <= w_ovf;
      end else if (w_restore) begin
        r_acc[w_rest_idx] <= w_rest_val;
        r_ovf             <= 1'b0;
      end
    end
  end

  assign led  = r_acc[acc_sel];
  assign zero = (led == '0);
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_calc_bank.sv
// tb/tb_calc_bank.sv - self-checking bench running wrapping and saturating builds side by side
module tb_calc_bank;

  localparam int W  = 16;
  localparam int NA = 4;
  localparam int HD = 8;

  logic        clk = 1'b0;
  logic        btnu, btnc, btnl, btnr, btnd, btn_undo;
  logic [1:0]  acc_sel;
  logic [15:0] sw;
  logic [15:0] led_w, led_s;
  logic        zero_w, zero_s, ovf_w, ovf_s;
  logic [3:0]  hc_w, hc_s;

  always #5 clk = ~clk;

  calc_bank #(.WIDTH(W), .NUM_ACC(NA), .HIST_DEPTH(HD), .SATURATE(0)) dut_wrap (
    .clk(clk), .btnu(btnu), .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnd(btnd),
    .btn_undo(btn_undo), .acc_sel(acc_sel), .sw(sw), .led(led_w), .zero(zero_w),
    .ovf(ovf_w), .hist_cnt(hc_w));

  calc_bank #(.WIDTH(W), .NUM_ACC(NA), .HIST_DEPTH(HD), .SATURATE(1)) dut_sat (
    .clk(clk), .btnu(btnu), .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnd(btnd),
    .btn_undo(btn_undo), .acc_sel(acc_sel), .sw(sw), .led(led_s), .zero(zero_s),
    .ovf(ovf_s), .hist_cnt(hc_s));

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: index 0 wraps, index 1 saturates.
  typedef struct { int idx; int val; } hent_t;
  int    m_acc [2][NA];
  bit    m_ovf [2];
  hent_t hq0[$];
  hent_t hq1[$];
  bit    m_bd_q, m_un_q;

  typedef struct {
    logic [15:0] a; logic [2:0] op; logic [15:0] b;
    logic [15:0] rw; logic ow; logic [15:0] rs; logic os;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int to_s(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic void alu(input int a, input int b, input int op, input bit sat,
                              output int r, output bit o);
    int sa, sb, sh, t;
    sa = to_s(a); sb = to_s(b); sh = b % 16;
    o = 1'b0;
    case (op)
      0, 1: begin
        t = (op == 0) ? sa + sb : sa - sb;
        if (t > 32767) begin o = 1'b1; t = sat ? 32767 : t - 65536; end
        else if (t < -32768) begin o = 1'b1; t = sat ? -32768 : t + 65536; end
        r = t & 'hFFFF;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << sh) & 'hFFFF;
      6: r = (sa >>> sh) & 'hFFFF;
      default: r = b;
    endcase
  endfunction

  function automatic int hsize(input int m);
    return (m == 0) ? hq0.size() : hq1.size();
  endfunction

  task automatic model_step();
    int op, r, sel;
    bit o, com, und;
    hent_t e;
    if (btnu) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < NA; i++) m_acc[m][i] = 0;
        m_ovf[m] = 1'b0;
      end
      hq0.delete(); hq1.delete();
      m_bd_q = 1'b1; m_un_q = 1'b1;
      return;
    end
    op  = {btnc, btnl, btnr};
    sel = acc_sel;
    com = btnd && !m_bd_q;
    und = btn_undo && !m_un_q;
    m_bd_q = btnd; m_un_q = btn_undo;
    for (int m = 0; m < 2; m++) begin
      if (com) begin
        alu(m_acc[m][sel], sw, op, m == 1, r, o);
        e.idx = sel; e.val = m_acc[m][sel];
        if (m == 0) begin hq0.push_back(e); if (hq0.size() > HD) hq0.delete(0); end
        else        begin hq1.push_back(e); if (hq1.size() > HD) hq1.delete(0); end
        m_acc[m][sel] = r;
        m_ovf[m] = o;
      end else if (und && hsize(m) > 0) begin
        e = (m == 0) ? hq0.pop_back() : hq1.pop_back();
        m_acc[m][e.idx] = e.val;
        m_ovf[m] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name);
    chk({name, " led_w"},  led_w,  m_acc[0][acc_sel]);
    chk({name, " led_s"},  led_s,  m_acc[1][acc_sel]);
    chk({name, " zero_w"}, zero_w, m_acc[0][acc_sel] == 0);
    chk({name, " zero_s"}, zero_s, m_acc[1][acc_sel] == 0);
    chk({name, " ovf_w"},  ovf_w,  m_ovf[0]);
    chk({name, " ovf_s"},  ovf_s,  m_ovf[1]);
    chk({name, " hist_w"}, hc_w,   hq0.size());
    chk({name, " hist_s"}, hc_s,   hq1.size());
  endtask

  task automatic check_bank(input string name);
    logic [1:0] keep;
    keep = acc_sel;
    for (int i = 0; i < NA; i++) begin
      acc_sel = i[1:0];
      #1;
      chk({name, " bank_w"}, led_w, m_acc[0][i]);
      chk({name, " bank_s"}, led_s, m_acc[1][i]);
    end
    acc_sel = keep;
  endtask

  task automatic set_op(input int op);
    logic [2:0] o3;
    o3 = op[2:0];
    {btnc, btnl, btnr} = o3;
  endtask

  task automatic press(input int op, input int sel, input logic [15:0] b);
    set_op(op);
    acc_sel = sel[1:0];
    sw = b;
    btnd = 1'b1;
    tick();
    btnd = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    btnu = 1'b1;
    tick();
    btnu = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] pool[5];
    int snap[2][NA];
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h7FFF;
    pool[3] = 16'h8000; pool[4] = 16'hFFFF;

    btnu = 1'b1; btnc = 0; btnl = 0; btnr = 0; btnd = 0; btn_undo = 0;
    acc_sel = 0; sw = 0;
    m_bd_q = 1'b1; m_un_q = 1'b1;
    tick();
    btnu = 1'b0;
    tick();
    check_outs("reset");
    check_bank("reset");

    // Single commit, then held button must not repeat.
    set_op(0); acc_sel = 0; sw = 16'h0005; btnd = 1'b1;
    tick();
    chk("first add led", led_w, 16'h0005);
    chk("first add hist", hc_w, 4'd1);
    chk("first add ovf", ovf_w, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("held led", led_w, 16'h0005);
    chk("held hist", hc_w, 4'd1);
    btnd = 1'b0;
    tick();
    check_outs("held");

    vt[0]  = '{16'h0000, 3'd0, 16'h0005, 16'h0005, 1'b0, 16'h0005, 1'b0};
    vt[1]  = '{16'h7FFF, 3'd0, 16'h0001, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
    vt[2]  = '{16'h8000, 3'd1, 16'h0001, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
    vt[3]  = '{16'h8000, 3'd0, 16'hFFFF, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
    vt[4]  = '{16'h0003, 3'd1, 16'h0005, 16'hFFFE, 1'b0, 16'hFFFE, 1'b0};
    vt[5]  = '{16'hF0F0, 3'd2, 16'h0FF0, 16'h00F0, 1'b0, 16'h00F0, 1'b0};
    vt[6]  = '{16'hF000, 3'd3, 16'h000F, 16'hF00F, 1'b0, 16'hF00F, 1'b0};
    vt[7]  = '{16'hFFFF, 3'd4, 16'h0F0F, 16'hF0F0, 1'b0, 16'hF0F0, 1'b0};
    vt[8]  = '{16'h0F0F, 3'd5, 16'h0004, 16'hF0F0, 1'b0, 16'hF0F0, 1'b0};
    vt[9]  = '{16'hF000, 3'd6, 16'h0004, 16'hFF00, 1'b0, 16'hFF00, 1'b0};
    vt[10] = '{16'h1234, 3'd7, 16'hABCD, 16'hABCD, 1'b0, 16'hABCD, 1'b0};
    vt[11] = '{16'h7FFF, 3'd1, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
    vt[12] = '{16'h8001, 3'd6, 16'h000F, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0};
    vt[13] = '{16'h0001, 3'd5, 16'h0013, 16'h0008, 1'b0, 16'h0008, 1'b0};
    vt[14] = '{16'h4000, 3'd0, 16'h4000, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
    vt[15] = '{16'h8000, 3'd1, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0};

    for (int i = 0; i < 16; i++) begin
      press(7, 0, vt[i].a);
      press(vt[i].op, 0, vt[i].b);
      chk($sformatf("vec%0d led_w", i), led_w, vt[i].rw);
      chk($sformatf("vec%0d ovf_w", i), ovf_w, vt[i].ow);
      chk($sformatf("vec%0d led_s", i), led_s, vt[i].rs);
      chk($sformatf("vec%0d ovf_s", i), ovf_s, vt[i].os);
      check_outs($sformatf("vec%0d", i));
    end

    // Undo restores into the recorded accumulator, not the selected one.
    do_reset();
    press(7, 1, 16'h1234);
    press(0, 1, 16'h7000);
    chk("undo pre ovf", ovf_w, 1'b1);
    acc_sel = 2'd2;
    btn_undo = 1'b1; tick(); btn_undo = 1'b0; tick();
    chk("undo1 led", led_w, 16'h0000);
    chk("undo1 hist", hc_w, 4'd1);
    chk("undo1 ovf", ovf_w, 1'b0);
    check_bank("undo1");
    btn_undo = 1'b1; tick(); btn_undo = 1'b0; tick();
    chk("undo2 hist", hc_w, 4'd0);
    check_bank("undo2");

    // Overfill history, then drain past empty.
    do_reset();
    for (int i = 0; i < HD + 2; i++) begin
      press($urandom_range(0, 7), $urandom_range(0, 3), 16'($urandom));
      if (i == 1) for (int k = 0; k < NA; k++) begin snap[0][k] = m_acc[0][k]; snap[1][k] = m_acc[1][k]; end
    end
    chk("full hist", hc_w, 4'd8);
    for (int i = 0; i < HD + 1; i++) begin
      btn_undo = 1'b1; tick(); btn_undo = 1'b0; tick();
      check_outs("drain");
    end
    chk("drained hist", hc_w, 4'd0);
    for (int k = 0; k < NA; k++) begin
      acc_sel = k[1:0];
      #1;
      chk("drained snap_w", led_w, snap[0][k]);
      chk("drained snap_s", led_s, snap[1][k]);
    end

    // Commit and undo rising together: commit only.
    do_reset();
    press(7, 0, 16'h0011);
    set_op(0); sw = 16'h0001; btnd = 1'b1; btn_undo = 1'b1;
    tick();
    chk("simul led", led_w, 16'h0012);
    chk("simul hist", hc_w, 4'd2);
    btnd = 1'b0; btn_undo = 1'b0;
    tick();
    check_outs("simul");

    // Reset wins over a commit; held button across release does not fire.
    set_op(7); sw = 16'hFFFF; btnu = 1'b1; btnd = 1'b1;
    tick();
    chk("rst commit led", led_w, 16'h0000);
    chk("rst commit hist", hc_w, 4'd0);
    btnu = 1'b0;
    tick(); tick();
    chk("held release led", led_w, 16'h0000);
    chk("held release hist", hc_w, 4'd0);
    btnd = 1'b0; tick();
    btnd = 1'b1; tick();
    chk("repress led", led_w, 16'hFFFF);
    chk("repress hist", hc_w, 4'd1);
    btnd = 1'b0; tick();
    check_bank("repress");

    // Random soak against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      btnu     = ($urandom_range(0, 63) == 0);
      btnd     = ($urandom_range(0, 2) == 0);
      btn_undo = ($urandom_range(0, 3) == 0);
      set_op($urandom_range(0, 7));
      acc_sel  = 2'($urandom_range(0, 3));
      sw       = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 4)] : 16'($urandom);
      tick();
      check_outs("rand");
    end
    btnu = 1'b0; btnd = 1'b0; btn_undo = 1'b0;
    tick();
    check_bank("rand end");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
